// File: rtl/craft_pkg.sv
// Shared CRAFT definitions: state geometry, the 4-bit S-box table and the
// SubCell FSM state encoding.
package craft_pkg;

    localparam int CRAFT_NIBBLES = 16;
    localparam int CRAFT_STATE_W = 64;

    // Entry i sits at bits [4i+3:4i]; entry 0 is the least significant nibble.
    localparam logic [63:0] CRAFT_SBOX_TABLE = 64'h6420_5198_7fbe_3dac;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } craft_state_e;

    function automatic logic [3:0] craft_sbox_f(input logic [3:0] nib);
        return CRAFT_SBOX_TABLE[{nib, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/craft_sbox.sv
// Combinational CRAFT 4-bit S-box (an involution).
module craft_sbox
    import craft_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = craft_sbox_f(din);

endmodule

// File: rtl/craft_sbox_layer_serial.sv
// CRAFT SubCell layer applied LANES nibbles per clock, with valid/ready
// handshakes on both sides.
module craft_sbox_layer_serial
    import craft_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int STATE_W = CRAFT_STATE_W
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_data,
    output logic               busy
);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("craft_sbox_layer_serial: LANES must be 1, 2, 4, 8 or 16");
    end
    if (STATE_W != CRAFT_STATE_W) begin : g_bad_width
        $error("craft_sbox_layer_serial: STATE_W must be 64");
    end

    // LANES=16 steps the counter by 16, i.e. it stays at 0.
    localparam logic [3:0] CNT_STEP = 4'(LANES % CRAFT_NIBBLES);
    localparam logic [3:0] CNT_LAST = 4'(CRAFT_NIBBLES - LANES);

    craft_state_e               state_q;
    logic [3:0]                 cnt_q;
    logic [CRAFT_STATE_W-1:0]   sreg_q;
    logic [CRAFT_STATE_W-1:0]   sreg_d;
    logic                       out_valid_q;
    logic [CRAFT_STATE_W-1:0]   out_data_q;
    logic                       accept_s;
    logic                       last_step_s;

    logic [3:0] lane_idx [LANES];
    logic [3:0] lane_in  [LANES];
    logic [3:0] lane_out [LANES];

    // cnt is always a multiple of LANES, so cnt+l never wraps within a step.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_idx[l] = cnt_q + 4'(l);
        assign lane_in[l]  = sreg_q[{lane_idx[l], 2'b00} +: 4];

        craft_sbox u_sbox (
            .din  (lane_in[l]),
            .dout (lane_out[l])
        );
    end

    // Next state register: substitute the selected lanes, hold the rest.
    always_comb begin
        sreg_d = sreg_q;
        for (int l = 0; l < LANES; l++) begin
            sreg_d[{lane_idx[l], 2'b00} +: 4] = lane_out[l];
        end
    end

    assign in_ready    = RST_N && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept_s    = in_valid && in_ready;
    assign last_step_s = (cnt_q == CNT_LAST);

    // Control FSM, counter, state register and registered output stage.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            sreg_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        sreg_q  <= in_data;
                        cnt_q   <= 4'd0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    sreg_q <= sreg_d;
                    if (last_step_s) begin
                        cnt_q       <= 4'd0;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        out_data_q  <= sreg_d;
                    end else begin
                        cnt_q <= cnt_q + CNT_STEP;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (accept_s) begin
                            sreg_q  <= in_data;
                            cnt_q   <= 4'd0;
                            state_q <= BUSY;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= 4'd0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q == BUSY);

endmodule

// File: tb/tb_craft_sbox_layer_serial.sv
// Randomized self-checking bench for craft_sbox_layer_serial with LANES = 4, 1 and 16.
module tb_craft_sbox_layer_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid_s  [3];
    logic [63:0] in_data_s   [3];
    logic        out_ready_s [3];
    logic        in_ready_s  [3];
    logic        out_valid_s [3];
    logic [63:0] out_data_s  [3];
    logic        busy_s      [3];

    int checks_total  = 0;
    int checks_passed = 0;

    // Index 0: LANES=4, 1: LANES=1, 2: LANES=16
    int lat_tab  [3] = '{5, 17, 2};
    int busy_tab [3] = '{4, 16, 1};
    int sbox_tab [16] = '{12, 10, 13, 3, 14, 11, 15, 7, 8, 9, 1, 5, 0, 2, 4, 6};

    craft_sbox_layer_serial #(.LANES(4)) u_l4 (
        .CLK(clk), .RST_N(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .in_data(in_data_s[0]), .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
        .out_data(out_data_s[0]), .busy(busy_s[0]));

    craft_sbox_layer_serial #(.LANES(1)) u_l1 (
        .CLK(clk), .RST_N(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .in_data(in_data_s[1]), .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
        .out_data(out_data_s[1]), .busy(busy_s[1]));

    craft_sbox_layer_serial #(.LANES(16)) u_l16 (
        .CLK(clk), .RST_N(rst_n), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
        .in_data(in_data_s[2]), .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]),
        .out_data(out_data_s[2]), .busy(busy_s[2]));

    function automatic logic [63:0] ref_sub(input logic [63:0] s);
        logic [63:0] r = 64'd0;
        for (int i = 0; i < 16; i++) begin
            r = r | (64'(sbox_tab[int'((s >> (4 * i)) & 64'hf)]) << (4 * i));
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input int k, input logic [63:0] data);
        in_data_s[k]  = data;
        in_valid_s[k] = 1'b1;
        tick();
        in_valid_s[k] = 1'b0;
        in_data_s[k]  = {$urandom(), $urandom()};
    endtask

    // Edges counted from the accept edge (inclusive) to the first out_valid.
    task automatic wait_done(input int k, output int edges, output int busy_cnt);
        edges    = 1;
        busy_cnt = busy_s[k] ? 1 : 0;
        while (!out_valid_s[k] && edges < 64) begin
            tick();
            edges++;
            if (busy_s[k]) busy_cnt++;
        end
    endtask

    task automatic run_single(input int k, input logic [63:0] data);
        int edges, busy_cnt;
        logic [63:0] exp_v = ref_sub(data);
        accept(k, data);
        wait_done(k, edges, busy_cnt);
        checks_total++;
        if (edges !== lat_tab[k]) $display("FAIL latency[%0d] got %0d exp %0d", k, edges, lat_tab[k]);
        else checks_passed++;
        checks_total++;
        if (busy_cnt !== busy_tab[k]) $display("FAIL busy_cycles[%0d] got %0d exp %0d", k, busy_cnt, busy_tab[k]);
        else checks_passed++;
        checks_total++;
        if (out_data_s[k] !== exp_v) $display("FAIL out_data[%0d] in %h got %h exp %h", k, data, out_data_s[k], exp_v);
        else checks_passed++;
        out_ready_s[k] = 1'b1;
        tick();
        out_ready_s[k] = 1'b0;
        checks_total++;
        if (out_valid_s[k] !== 1'b0 || out_data_s[k] !== exp_v)
            $display("FAIL drain[%0d] got valid %b data %h exp valid 0 data %h", k, out_valid_s[k], out_data_s[k], exp_v);
        else checks_passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            checks_total++;
            if (out_valid_s[k] !== 1'b0 || out_data_s[k] !== 64'd0 || busy_s[k] !== 1'b0 || in_ready_s[k] !== 1'b0)
                $display("FAIL reset[%0d] got v%b d%h b%b r%b exp v0 d0 b0 r0", k, out_valid_s[k], out_data_s[k], busy_s[k], in_ready_s[k]);
            else checks_passed++;
        end
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks_total++;
            if (in_ready_s[k] !== 1'b1) $display("FAIL reset_ready[%0d] got %b exp 1", k, in_ready_s[k]);
            else checks_passed++;
        end
    endtask

    task automatic test_known_vectors();
        logic [63:0] got;
        run_single(0, 64'h0123456789abcdef);
        got = out_data_s[0];
        checks_total++;
        if (got !== 64'hcad3ebf789150246) $display("FAIL known_vec got %h exp cad3ebf789150246", got);
        else checks_passed++;
        run_single(0, got);
        checks_total++;
        if (out_data_s[0] !== 64'h0123456789abcdef) $display("FAIL involution got %h exp 0123456789abcdef", out_data_s[0]);
        else checks_passed++;
        run_single(1, 64'h0123456789abcdef);
        run_single(2, 64'hcad3ebf789150246);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            for (int k = 0; k < 3; k++) begin
                run_single(k, {$urandom(), $urandom()});
            end
        end
    endtask

    task automatic test_backpressure();
        int edges, busy_cnt;
        accept(0, 64'h0123456789abcdef);
        wait_done(0, edges, busy_cnt);
        for (int c = 0; c < 6; c++) begin
            checks_total++;
            if (out_valid_s[0] !== 1'b1 || out_data_s[0] !== 64'hcad3ebf789150246 || in_ready_s[0] !== 1'b0)
                $display("FAIL backpressure[%0d] got v%b d%h r%b exp v1 dcad3ebf789150246 r0", c, out_valid_s[0], out_data_s[0], in_ready_s[0]);
            else checks_passed++;
            tick();
        end
        out_ready_s[0] = 1'b1;
        tick();
        out_ready_s[0] = 1'b0;
        checks_total++;
        if (out_valid_s[0] !== 1'b0 || busy_s[0] !== 1'b0) $display("FAIL bp_release got v%b b%b exp v0 b0", out_valid_s[0], busy_s[0]);
        else checks_passed++;
    endtask

    task automatic test_back_to_back();
        int edges, busy_cnt;
        out_ready_s[0] = 1'b1;
        in_valid_s[0]  = 1'b1;
        in_data_s[0]   = 64'hffffffffffffffff;
        tick();
        in_data_s[0]   = 64'h0000000000000000;
        wait_done(0, edges, busy_cnt);
        checks_total++;
        if (out_data_s[0] !== 64'h6666666666666666 || in_ready_s[0] !== 1'b1 || edges !== 5)
            $display("FAIL b2b_first got d%h r%b lat%0d exp d6666666666666666 r1 lat5", out_data_s[0], in_ready_s[0], edges);
        else checks_passed++;
        tick();
        in_valid_s[0] = 1'b0;
        checks_total++;
        if (out_valid_s[0] !== 1'b0 || busy_s[0] !== 1'b1) $display("FAIL b2b_restart got v%b b%b exp v0 b1", out_valid_s[0], busy_s[0]);
        else checks_passed++;
        wait_done(0, edges, busy_cnt);
        checks_total++;
        if (out_data_s[0] !== 64'hcccccccccccccccc || edges !== 5)
            $display("FAIL b2b_second got d%h lat%0d exp dcccccccccccccccc lat5", out_data_s[0], edges);
        else checks_passed++;
        tick();
        out_ready_s[0] = 1'b0;
        checks_total++;
        if (out_valid_s[0] !== 1'b0 || busy_s[0] !== 1'b0) $display("FAIL b2b_idle got v%b b%b exp v0 b0", out_valid_s[0], busy_s[0]);
        else checks_passed++;
    endtask

    task automatic test_reset_mid_busy();
        logic seen = 1'b0;
        accept(0, 64'h0123456789abcdef);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        checks_total++;
        if (out_valid_s[0] !== 1'b0 || out_data_s[0] !== 64'd0 || busy_s[0] !== 1'b0 || in_ready_s[0] !== 1'b1)
            $display("FAIL mid_reset got v%b d%h b%b r%b exp v0 d0 b0 r1", out_valid_s[0], out_data_s[0], busy_s[0], in_ready_s[0]);
        else checks_passed++;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (out_valid_s[0] || busy_s[0]) seen = 1'b1;
        end
        checks_total++;
        if (seen !== 1'b0) $display("FAIL aborted_output got %b exp 0", seen);
        else checks_passed++;
    endtask

    task automatic test_exhaustive();
        int edges, busy_cnt;
        logic [63:0] data;
        int bad;
        for (int v = 0; v < 16; v++) begin
            data = {16{4'(v)}};
            accept(0, data);
            wait_done(0, edges, busy_cnt);
            bad = 0;
            for (int i = 0; i < 16; i++) begin
                if (int'((out_data_s[0] >> (4 * i)) & 64'hf) != sbox_tab[v]) bad++;
            end
            checks_total++;
            if (bad != 0) $display("FAIL exhaustive v=%0h got %h exp every nibble %0h", v, out_data_s[0], sbox_tab[v]);
            else checks_passed++;
            out_ready_s[0] = 1'b1;
            tick();
            out_ready_s[0] = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid_s[k]  = 1'b0;
            in_data_s[k]   = 64'd0;
            out_ready_s[k] = 1'b0;
        end
        test_reset();
        test_known_vectors();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_busy();
        test_exhaustive();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
